// File: rtl/twiddle_pkg.sv
// Shared defaults, FSM encoding and quarter-wave cosine table generator for the twiddle sequencer.
package twiddle_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_FRAC_W    = 8;
  localparam int DEF_LOG2N_MAX = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } tw_state_e;

  // pi scaled by 2^28; the series below runs in that fixed-point format
  localparam longint PI_FX = 64'sd843314857;

  function automatic int cos_entry(input int i, input int frac_w, input int log2n);
    longint x;
    longint x2;
    longint term;
    longint acc;
    x    = (PI_FX * 64'sd2 * longint'(i)) >>> log2n;
    x2   = (x * x) >>> 28;
    term = 64'sd1 <<< 28;
    acc  = term;
    for (int n = 1; n <= 12; n++) begin
      term = -((term * x2) >>> 28) / longint'((2 * n - 1) * (2 * n));
      acc  = acc + term;
    end
    return int'((acc * (64'sd1 <<< frac_w) + (64'sd1 <<< 27)) >>> 28);
  endfunction

endpackage

// File: rtl/twiddle_quarter_rom.sv
// Quarter-wave cosine ROM, Q+1 entries, two synchronous read ports sharing one enable.
module twiddle_quarter_rom
  import twiddle_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int FRAC_W    = DEF_FRAC_W,
  parameter int LOG2N_MAX = DEF_LOG2N_MAX,
  localparam int Q  = (1 << LOG2N_MAX) / 4,
  localparam int AW = $clog2(Q + 1)
) (
  input  logic              clk,
  input  logic              en,
  input  logic [AW-1:0]     addr_a,
  input  logic [AW-1:0]     addr_b,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b
);

  logic [DATA_W-1:0] tab [Q+1];
  logic [DATA_W-1:0] rd_a_d, rd_a_q;
  logic [DATA_W-1:0] rd_b_d, rd_b_q;

  for (genvar i = 0; i <= Q; i++) begin : g_tab
    localparam int CV = cos_entry(i, FRAC_W, LOG2N_MAX);
    assign tab[i] = DATA_W'(CV);
  end

  always_comb begin
    rd_a_d = en ? tab[addr_a] : rd_a_q;
    rd_b_d = en ? tab[addr_b] : rd_b_q;
  end

  always_ff @(posedge clk) begin
    rd_a_q <= rd_a_d;
    rd_b_q <= rd_b_d;
  end

  assign rd_a = rd_a_q;
  assign rd_b = rd_b_q;

endmodule

// File: rtl/twiddle_stream_gen.sv
// Streams W_M^k (or its conjugate) for k = 0..M/2-1 from one quarter-wave table; 2-cycle latency.
// Whole pipeline freezes while tw_valid && !out_ready, so a presented beat holds until taken.
module twiddle_stream_gen
  import twiddle_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int FRAC_W    = DEF_FRAC_W,
  parameter int LOG2N_MAX = DEF_LOG2N_MAX,
  localparam int SW = $clog2(LOG2N_MAX + 1),
  localparam int IW = LOG2N_MAX - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SW-1:0]     stage,
  input  logic              inverse,
  input  logic              out_ready,
  output logic              tw_valid,
  output logic [DATA_W-1:0] tw_re,
  output logic [DATA_W-1:0] tw_im,
  output logic [IW-1:0]     tw_idx,
  output logic              tw_last,
  output logic              busy,
  output logic              err
);

  localparam int Q  = (1 << LOG2N_MAX) / 4;
  localparam int AW = $clog2(Q + 1);

  tw_state_e         state_q, state_d;
  logic [IW-1:0]     k_q, k_d;
  logic [SW-1:0]     s_q, s_d;
  logic              inv_q, inv_d, busy_q, busy_d, err_q, err_d;
  logic              a_vld_q, a_vld_d, a_fold_q, a_fold_d, a_inv_q, a_inv_d, a_last_q, a_last_d;
  logic [IW-1:0]     a_idx_q, a_idx_d;
  logic              tw_valid_q, tw_valid_d, tw_last_q, tw_last_d;
  logic [DATA_W-1:0] tw_re_q, tw_re_d, tw_im_q, tw_im_d;
  logic [IW-1:0]     tw_idx_q, tw_idx_d;

  logic              adv, fold, k_last;
  logic [SW-1:0]     sh;
  logic [IW-1:0]     p, pd;
  logic [AW-1:0]     rom_addr_a, rom_addr_b;
  logic [DATA_W-1:0] rom_a, rom_b;

  assign adv = !tw_valid_q || out_ready;

  // Fold the half-circle phase onto the quarter table: port A feeds re, port B feeds im
  always_comb begin
    sh         = SW'(LOG2N_MAX) - s_q;
    p          = k_q << sh;
    fold       = p > IW'(Q);
    pd         = p - IW'(Q);
    rom_addr_a = fold ? AW'(IW'(Q) - pd) : AW'(p);
    rom_addr_b = fold ? AW'(pd) : AW'(IW'(Q) - p);
    k_last     = (k_q == IW'((1 << (s_q - SW'(1))) - 1));
  end

  twiddle_quarter_rom #(
    .DATA_W    (DATA_W),
    .FRAC_W    (FRAC_W),
    .LOG2N_MAX (LOG2N_MAX)
  ) u_rom (
    .clk    (clk),
    .en     (adv),
    .addr_a (rom_addr_a),
    .addr_b (rom_addr_b),
    .rd_a   (rom_a),
    .rd_b   (rom_b)
  );

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    s_d        = s_q;
    inv_d      = inv_q;
    busy_d     = busy_q;
    err_d      = 1'b0;
    a_vld_d    = a_vld_q;
    a_fold_d   = a_fold_q;
    a_inv_d    = a_inv_q;
    a_last_d   = a_last_q;
    a_idx_d    = a_idx_q;
    tw_valid_d = tw_valid_q;
    tw_re_d    = tw_re_q;
    tw_im_d    = tw_im_q;
    tw_idx_d   = tw_idx_q;
    tw_last_d  = tw_last_q;

    if (adv) a_vld_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (stage == '0 || stage > SW'(LOG2N_MAX)) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_RUN;
            s_d     = stage;
            inv_d   = inverse;
            k_d     = '0;
            busy_d  = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (adv) begin
          a_vld_d  = 1'b1;
          a_idx_d  = k_q;
          a_last_d = k_last;
          a_fold_d = fold;
          a_inv_d  = inv_q;
          if (k_last) state_d = ST_DRAIN;
          else         k_d     = k_q + IW'(1);
        end
      end
      ST_DRAIN: begin
        if (tw_valid_q && out_ready && tw_last_q) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Both table-derived im cases carry a minus sign; the conjugate simply drops it
    if (adv) begin
      tw_valid_d = a_vld_q;
      tw_re_d    = '0;
      tw_im_d    = '0;
      tw_idx_d   = '0;
      tw_last_d  = 1'b0;
      if (a_vld_q) begin
        tw_re_d   = a_fold_q ? -rom_a : rom_a;
        tw_im_d   = a_inv_q ? rom_b : -rom_b;
        tw_idx_d  = a_idx_q;
        tw_last_d = a_last_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      s_q        <= '0;
      inv_q      <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      a_vld_q    <= 1'b0;
      a_fold_q   <= 1'b0;
      a_inv_q    <= 1'b0;
      a_last_q   <= 1'b0;
      a_idx_q    <= '0;
      tw_valid_q <= 1'b0;
      tw_re_q    <= '0;
      tw_im_q    <= '0;
      tw_idx_q   <= '0;
      tw_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      s_q        <= s_d;
      inv_q      <= inv_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      a_vld_q    <= a_vld_d;
      a_fold_q   <= a_fold_d;
      a_inv_q    <= a_inv_d;
      a_last_q   <= a_last_d;
      a_idx_q    <= a_idx_d;
      tw_valid_q <= tw_valid_d;
      tw_re_q    <= tw_re_d;
      tw_im_q    <= tw_im_d;
      tw_idx_q   <= tw_idx_d;
      tw_last_q  <= tw_last_d;
    end
  end

  assign tw_valid = tw_valid_q;
  assign tw_re    = tw_re_q;
  assign tw_im    = tw_im_q;
  assign tw_idx   = tw_idx_q;
  assign tw_last  = tw_last_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_twiddle_stream_gen.sv
// Directed bench for twiddle_stream_gen with hand-computed twiddle tables.
module tb_twiddle_stream_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  stage = 3'd0;
  logic        inverse = 1'b0;
  logic        out_ready = 1'b1;
  logic        tw_valid;
  logic [15:0] tw_re;
  logic [15:0] tw_im;
  logic [4:0]  tw_idx;
  logic        tw_last;
  logic        busy;
  logic        err;

  int n_chk  = 0;
  int n_pass = 0;
  int lat;

  logic [15:0] exp_re [8];
  logic [15:0] exp_im [8];
  logic [15:0] got_re [8];
  logic [15:0] got_im [8];
  logic [4:0]  got_idx [8];
  logic        got_last [8];

  twiddle_stream_gen dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stage     (stage),
    .inverse   (inverse),
    .out_ready (out_ready),
    .tw_valid  (tw_valid),
    .tw_re     (tw_re),
    .tw_im     (tw_im),
    .tw_idx    (tw_idx),
    .tw_last   (tw_last),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic set_exp(input int i, input logic [15:0] re, input logic [15:0] im);
    exp_re[i] = re;
    exp_im[i] = im;
  endtask

  task automatic do_start(input logic [2:0] st, input logic inv);
    @(posedge clk); #1;
    start = 1'b1; stage = st; inverse = inv;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_valid"}, 32'(tw_valid), 32'd0);
    chk({tag, "_busy"},  32'(busy),     32'd0);
    chk({tag, "_re"},    32'(tw_re),    32'd0);
    chk({tag, "_im"},    32'(tw_im),    32'd0);
    chk({tag, "_idx"},   32'(tw_idx),   32'd0);
    chk({tag, "_last"},  32'(tw_last),  32'd0);
    chk({tag, "_err"},   32'(err),      32'd0);
  endtask

  // Accepts beats until tw_last is taken; optionally withholds out_ready on beat stall_k
  task automatic collect(input string tag, input int n_exp, input int stall_k,
                         input int stall_n, output int first_lat);
    int  got = 0;
    int  stalls = 0;
    int  cyc = 0;
    bit  done = 1'b0;
    bit  err_seen = 1'b0;
    first_lat = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (err) err_seen = 1'b1;
      if (tw_valid) begin
        if (first_lat == 0) first_lat = cyc;
        if (int'(tw_idx) == stall_k && stalls < stall_n) begin
          out_ready = 1'b0;
          stalls++;
          chk({tag, "_hold_re"},  32'(tw_re),  32'(exp_re[stall_k[2:0]]));
          chk({tag, "_hold_im"},  32'(tw_im),  32'(exp_im[stall_k[2:0]]));
          chk({tag, "_hold_idx"}, 32'(tw_idx), 32'(stall_k));
        end else begin
          out_ready = 1'b1;
          if (got < 8) begin
            got_re[got]   = tw_re;
            got_im[got]   = tw_im;
            got_idx[got]  = tw_idx;
            got_last[got] = tw_last;
          end
          got++;
          if (tw_last) done = 1'b1;
        end
      end else begin
        out_ready = 1'b1;
      end
    end
    out_ready = 1'b1;
    chk({tag, "_done"},  32'(done),     32'd1);
    chk({tag, "_beats"}, 32'(got),      32'(n_exp));
    chk({tag, "_noerr"}, 32'(err_seen), 32'd0);
    for (int i = 0; i < n_exp && i < got && i < 8; i++) begin
      chk($sformatf("%s_re%0d", tag, i),   32'(got_re[i]),   32'(exp_re[i]));
      chk($sformatf("%s_im%0d", tag, i),   32'(got_im[i]),   32'(exp_im[i]));
      chk($sformatf("%s_idx%0d", tag, i),  32'(got_idx[i]),  32'(i));
      chk($sformatf("%s_last%0d", tag, i), 32'(got_last[i]), 32'(i == n_exp - 1));
    end
    @(negedge clk);
    chk({tag, "_busy_end"},  32'(busy),     32'd0);
    chk({tag, "_valid_end"}, 32'(tw_valid), 32'd0);
  endtask

  initial begin
    bit any_v;
    bit any_b;

    // Reset state
    repeat (2) @(negedge clk);
    check_idle_outputs("rst_init");
    rst = 1'b0;

    // Reset asserted mid-sequence clears everything at once
    do_start(3'd4, 1'b0);
    repeat (4) @(negedge clk);
    chk("pre_rst_valid", 32'(tw_valid), 32'd1);
    rst = 1'b1;
    #1;
    check_idle_outputs("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // stage=2 after reset
    set_exp(0, 16'h0100, 16'h0000);
    set_exp(1, 16'h0000, 16'hFF00);
    do_start(3'd2, 1'b0);
    collect("s2", 2, -1, 0, lat);

    // stage=3 forward, with first-beat latency
    set_exp(0, 16'h0100, 16'h0000);
    set_exp(1, 16'h00B5, 16'hFF4B);
    set_exp(2, 16'h0000, 16'hFF00);
    set_exp(3, 16'hFF4B, 16'hFF4B);
    do_start(3'd3, 1'b0);
    collect("s3", 4, -1, 0, lat);
    chk("s3_latency", 32'(lat), 32'd3);

    // stage=3 inverse
    set_exp(0, 16'h0100, 16'h0000);
    set_exp(1, 16'h00B5, 16'h00B5);
    set_exp(2, 16'h0000, 16'h0100);
    set_exp(3, 16'hFF4B, 16'h00B5);
    do_start(3'd3, 1'b1);
    collect("s3inv", 4, -1, 0, lat);

    // stage=4 with a 3-cycle stall on k=2
    set_exp(0, 16'h0100, 16'h0000);
    set_exp(1, 16'h00ED, 16'hFF9E);
    set_exp(2, 16'h00B5, 16'hFF4B);
    set_exp(3, 16'h0062, 16'hFF13);
    set_exp(4, 16'h0000, 16'hFF00);
    set_exp(5, 16'hFF9E, 16'hFF13);
    set_exp(6, 16'hFF4B, 16'hFF4B);
    set_exp(7, 16'hFF13, 16'hFF9E);
    do_start(3'd4, 1'b0);
    collect("s4bp", 8, 2, 3, lat);

    // stage=1 single beat
    set_exp(0, 16'h0100, 16'h0000);
    do_start(3'd1, 1'b0);
    collect("s1", 1, -1, 0, lat);

    // Illegal stages
    do_start(3'd7, 1'b0);
    @(negedge clk);
    chk("s7_err_pulse", 32'(err), 32'd1);
    any_v = 1'b0;
    any_b = 1'b0;
    @(negedge clk);
    chk("s7_err_clear", 32'(err), 32'd0);
    repeat (4) begin
      @(negedge clk);
      if (tw_valid) any_v = 1'b1;
      if (busy) any_b = 1'b1;
    end
    chk("s7_no_valid", 32'(any_v), 32'd0);
    chk("s7_no_busy",  32'(any_b), 32'd0);
    do_start(3'd0, 1'b0);
    @(negedge clk);
    chk("s0_err_pulse", 32'(err), 32'd1);

    // start while busy is ignored; sequence keeps stage=3 forward
    set_exp(0, 16'h0100, 16'h0000);
    set_exp(1, 16'h00B5, 16'hFF4B);
    set_exp(2, 16'h0000, 16'hFF00);
    set_exp(3, 16'hFF4B, 16'hFF4B);
    do_start(3'd3, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; stage = 3'd5; inverse = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    collect("busy_start", 4, -1, 0, lat);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
